// File: rtl/mem_pkg.sv
// Shared types for the memory stage: MemOp encodings, exception codes,
// FSM states and the byte-lane helpers used by the EX/MEM stage.
package mem_pkg;

    typedef enum logic [3:0] {
        MOP_NONE = 4'd0,
        MOP_LW   = 4'd1,
        MOP_LH   = 4'd2,
        MOP_LHU  = 4'd3,
        MOP_LB   = 4'd4,
        MOP_LBU  = 4'd5,
        MOP_SW   = 4'd6,
        MOP_SH   = 4'd7,
        MOP_SB   = 4'd8
    } mem_op_e;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        mem_op_e     memop;
        logic [31:0] aluout;
        logic [31:0] wdata;
        logic [4:0]  regaddr;
        logic [31:0] pc;
    } ex_mem_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  byteen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    function automatic logic is_load(input mem_op_e op);
        return op inside {MOP_LW, MOP_LH, MOP_LHU, MOP_LB, MOP_LBU};
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return op inside {MOP_SW, MOP_SH, MOP_SB};
    endfunction

    function automatic logic misaligned(input mem_op_e op,
                                        input logic [1:0] a);
        case (op)
            MOP_LW, MOP_SW:          return a != 2'b00;
            MOP_LH, MOP_LHU, MOP_SH: return a[0];
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_lo(input mem_op_e op,
                                            input logic [1:0] a);
        case (op)
            MOP_LW, MOP_SW:          return 2'b00;
            MOP_LH, MOP_LHU, MOP_SH: return {a[1], 1'b0};
            default:                 return a;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input mem_op_e op,
                                           input logic [1:0] a);
        case (op)
            MOP_SH:  return a[1] ? 4'b1100 : 4'b0011;
            MOP_SB:  return 4'b0001 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] rep_data(input mem_op_e op,
                                             input logic [31:0] d);
        case (op)
            MOP_SB:  return {4{d[7:0]}};
            MOP_SH:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/stage_m_mem_load_ext.sv
// Load lane select and sign/zero extension for the memory stage.
module mem_load_ext
    import mem_pkg::*;
(
    input  mem_op_e     op_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    always_comb begin
        byte_w = rdata_i[7:0];
        unique case (addr_i)
            2'd0: byte_w = rdata_i[7:0];
            2'd1: byte_w = rdata_i[15:8];
            2'd2: byte_w = rdata_i[23:16];
            2'd3: byte_w = rdata_i[31:24];
            default: byte_w = rdata_i[7:0];
        endcase
        half_w = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (op_i)
            MOP_LH:  data_o = {{16{half_w[15]}}, half_w};
            MOP_LHU: data_o = {16'd0, half_w};
            MOP_LB:  data_o = {{24{byte_w[7]}}, byte_w};
            MOP_LBU: data_o = {24'd0, byte_w};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/stage_m_mem.sv
// EX/MEM register plus data-bus access unit feeding the MEM/WB flops.
// Optional MEM_ALIGN_CHECK_EN raises AdEL/AdES instead of forcing alignment.
module stage_m_mem
    import mem_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    input  logic [3:0]  MemOp_in,
    input  logic [31:0] ALUOut_in,
    input  logic [31:0] WriteData_in,
    input  logic [4:0]  RegAddr_in,
    input  logic [31:0] pc_in,
    output logic        stall_out,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_byteen,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic [31:0] ALUOut_out,
    output logic [4:0]  RegAddr_out,
    output logic [31:0] pc_out,
    output logic [31:0] ReadData_out,
    output logic        exc_valid_out,
    output logic [4:0]  exc_code_out
);

    ex_mem_t    s_q, s_d, s_in, bubble;
    mem_state_e st_q, st_d;
    bus_t       bus_q, bus_d, bus_now, bus_cur;
    logic       done_q, done_d;
    logic [1:0] ea_lo;
    logic       mis, is_mem, issue, acc, capture, stall;
    logic [31:0] ext_data;

    logic        w_rw_q, w_rw_d, w_mtr_q, w_mtr_d;
    logic [31:0] w_alu_q, w_alu_d, w_pc_q, w_pc_d;
    logic [4:0]  w_ra_q, w_ra_d;
    logic [31:0] rd_q, rd_d;
    logic        exc_v_q, exc_v_d;
    logic [4:0]  exc_c_q, exc_c_d;

    assign bubble = '{1'b0, 1'b0, MOP_NONE, 32'd0, 32'd0, 5'd0, EXC_PC};
    assign s_in   = '{RegWrite_in, MemToReg_in, mem_op_e'(MemOp_in),
                      ALUOut_in, WriteData_in, RegAddr_in, pc_in};

`ifdef MEM_ALIGN_CHECK_EN
    assign mis   = misaligned(s_q.memop, s_q.aluout[1:0]);
    assign ea_lo = s_q.aluout[1:0];
`else
    assign mis   = 1'b0;
    assign ea_lo = align_lo(s_q.memop, s_q.aluout[1:0]);
`endif

    assign is_mem = is_load(s_q.memop) || is_store(s_q.memop);

    assign bus_now = '{is_store(s_q.memop),
                       byte_en(s_q.memop, ea_lo),
                       {s_q.aluout[31:2], 2'b00},
                       rep_data(s_q.memop, s_q.wdata)};

    always_comb begin
        st_d    = st_q;
        bus_d   = bus_q;
        bus_cur = bus_q;
        issue   = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
                issue   = is_mem && !done_q && !mis && !req;
                bus_cur = bus_now;
                if (issue && !m_ack) begin
                    st_d  = ST_WAIT;
                    bus_d = bus_now;
                end
            end
            ST_WAIT: begin
                if (m_ack)    st_d = ST_IDLE;
                else if (req) st_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (m_ack) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    assign m_req    = issue || (st_q != ST_IDLE);
    assign m_we     = m_req && bus_cur.we;
    assign m_addr   = bus_cur.addr;
    assign m_byteen = bus_cur.byteen;
    assign m_wdata  = bus_cur.wdata;

    assign stall     = m_req && !m_ack;
    assign stall_out = stall;
    assign capture   = !stall && !req;
    // A drained transaction belongs to a flushed instruction.
    assign acc       = m_req && m_ack && (st_q != ST_DRAIN);

    assign s_d    = req ? bubble : (capture ? s_in : s_q);
    assign done_d = (req || capture) ? 1'b0 : (done_q || acc);

    mem_load_ext u_ext (
        .op_i    (s_q.memop),
        .addr_i  (ea_lo),
        .rdata_i (m_rdata),
        .data_o  (ext_data)
    );

    assign rd_d = (acc && !req && is_load(s_q.memop)) ? ext_data : rd_q;

    always_comb begin
        w_rw_d  = 1'b0;
        w_mtr_d = 1'b0;
        w_alu_d = 32'd0;
        w_ra_d  = 5'd0;
        w_pc_d  = s_q.pc;
        exc_v_d = 1'b0;
        exc_c_d = 5'd0;
        if (req) begin
            w_pc_d = EXC_PC;
        end else if (!stall) begin
            w_rw_d  = s_q.regwrite && !mis;
            w_mtr_d = s_q.memtoreg;
            w_alu_d = s_q.aluout;
            w_ra_d  = s_q.regaddr;
            exc_v_d = mis;
            if (mis) exc_c_d = is_load(s_q.memop) ? EXC_ADEL : EXC_ADES;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            bus_q  <= '0;
            done_q <= 1'b0;
            s_q    <= '{1'b0, 1'b0, MOP_NONE, 32'd0, 32'd0, 5'd0, RESET_PC};
        end else begin
            st_q   <= st_d;
            bus_q  <= bus_d;
            done_q <= done_d;
            s_q    <= s_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_rw_q  <= 1'b0;
            w_mtr_q <= 1'b0;
            w_alu_q <= 32'd0;
            w_ra_q  <= 5'd0;
            w_pc_q  <= RESET_PC;
            rd_q    <= 32'd0;
            exc_v_q <= 1'b0;
            exc_c_q <= 5'd0;
        end else begin
            w_rw_q  <= w_rw_d;
            w_mtr_q <= w_mtr_d;
            w_alu_q <= w_alu_d;
            w_ra_q  <= w_ra_d;
            w_pc_q  <= w_pc_d;
            rd_q    <= rd_d;
            exc_v_q <= exc_v_d;
            exc_c_q <= exc_c_d;
        end
    end

    assign RegWrite_out  = w_rw_q;
    assign MemToReg_out  = w_mtr_q;
    assign ALUOut_out    = w_alu_q;
    assign RegAddr_out   = w_ra_q;
    assign pc_out        = w_pc_q;
    assign ReadData_out  = rd_q;
    assign exc_valid_out = exc_v_q;
    assign exc_code_out  = exc_c_q;

endmodule

// File: tb/tb_stage_m_mem.sv
// Bench for stage_m_mem: directed cases plus random traffic against
// a transaction-level model of the stage, bus and W outputs.
module tb_stage_m_mem;
    import mem_pkg::*;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ACHK = 1'b1;
`else
    localparam bit ACHK = 1'b0;
`endif
    localparam logic [31:0] RPC = 32'h0000_3000;
    localparam logic [31:0] XPC = 32'h0000_4180;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req, RegWrite_in, MemToReg_in;
    logic [3:0]  MemOp_in;
    logic [31:0] ALUOut_in, WriteData_in, pc_in;
    logic [4:0]  RegAddr_in;
    logic        stall_out, m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_byteen;
    logic        RegWrite_out, MemToReg_out, exc_valid_out;
    logic [31:0] ALUOut_out, pc_out, ReadData_out;
    logic [4:0]  RegAddr_out, exc_code_out;

    stage_m_mem dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
        .MemOp_in(MemOp_in), .ALUOut_in(ALUOut_in),
        .WriteData_in(WriteData_in), .RegAddr_in(RegAddr_in),
        .pc_in(pc_in), .stall_out(stall_out), .m_req(m_req),
        .m_we(m_we), .m_addr(m_addr), .m_byteen(m_byteen),
        .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata),
        .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
        .ALUOut_out(ALUOut_out), .RegAddr_out(RegAddr_out),
        .pc_out(pc_out), .ReadData_out(ReadData_out),
        .exc_valid_out(exc_valid_out), .exc_code_out(exc_code_out)
    );

    typedef struct {
        logic        rw, mtr;
        logic [3:0]  op;
        logic [31:0] alu, wd, pc;
        logic [4:0]  ra;
    } ins_t;

    int tests = 0, fails = 0;

    // model state
    ins_t mi;
    bit   mdone, mbusy, mdrain;
    logic        mb_we;
    logic [3:0]  mb_be;
    logic [31:0] mb_addr, mb_wd;
    logic        mw_rw, mw_mtr, mexc;
    logic [31:0] mw_alu, mw_pc, mrd;
    logic [4:0]  mw_ra, mexc_c;
    int   cnt;

    // per-cycle stimulus and model combinational view
    ins_t d_in;
    logic d_req;
    int   d_wait;
    logic [31:0] d_rdata;
    logic e_req, e_stall, e_ack, e_mis, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd;

    function automatic bit is_ld(input logic [3:0] op);
        return op == MOP_LW || op == MOP_LH || op == MOP_LHU ||
               op == MOP_LB || op == MOP_LBU;
    endfunction

    function automatic bit is_st(input logic [3:0] op);
        return op == MOP_SW || op == MOP_SH || op == MOP_SB;
    endfunction

    function automatic bit mis_f(input logic [3:0] op, input logic [31:0] a);
        if (!ACHK) return 1'b0;
        if (op == MOP_LW || op == MOP_SW) return a[1:0] != 2'b00;
        if (op == MOP_LH || op == MOP_LHU || op == MOP_SH) return a[0];
        return 1'b0;
    endfunction

    function automatic logic [3:0] be_f(input logic [3:0] op, input logic [1:0] a);
        if (op == MOP_SH) return a[1] ? 4'b1100 : 4'b0011;
        if (op == MOP_SB) return 4'b0001 << a;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] wd_f(input logic [3:0] op, input logic [31:0] d);
        if (op == MOP_SB) return {4{d[7:0]}};
        if (op == MOP_SH) return {2{d[15:0]}};
        return d;
    endfunction

    function automatic logic [31:0] ext_f(input logic [3:0] op,
                                          input logic [1:0] a,
                                          input logic [31:0] r);
        logic [31:0] sb, sh;
        sb = r >> {a, 3'b000};
        sh = a[1] ? (r >> 16) : r;
        case (op)
            MOP_LB:  return {{24{sb[7]}}, sb[7:0]};
            MOP_LBU: return {24'd0, sb[7:0]};
            MOP_LH:  return {{16{sh[15]}}, sh[15:0]};
            MOP_LHU: return {16'd0, sh[15:0]};
            default: return r;
        endcase
    endfunction

    function automatic ins_t mk(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] d);
        ins_t t;
        t.rw  = is_ld(op);
        t.mtr = is_ld(op);
        t.op  = op;
        t.alu = a;
        t.wd  = d;
        t.ra  = 5'd3;
        t.pc  = 32'h0000_0100 + a;
        return t;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t t;
        t.op  = 4'($urandom_range(0, 8));
        t.rw  = 1'($urandom);
        t.mtr = 1'($urandom);
        t.alu = $urandom;
        t.wd  = $urandom;
        t.ra  = 5'($urandom);
        t.pc  = $urandom;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mi = '{1'b0, 1'b0, 4'd0, 32'd0, 32'd0, RPC, 5'd0};
        mdone = 0; mbusy = 0; mdrain = 0;
        mb_we = 0; mb_be = 0; mb_addr = 0; mb_wd = 0;
        mw_rw = 0; mw_mtr = 0; mw_alu = 0; mw_ra = 0; mw_pc = RPC;
        mrd = 0; mexc = 0; mexc_c = 0;
    endtask

    // At negedge: drive inputs, evaluate the model's view, check comb outputs.
    task automatic drive_cycle();
        req          = d_req;
        RegWrite_in  = d_in.rw;
        MemToReg_in  = d_in.mtr;
        MemOp_in     = d_in.op;
        ALUOut_in    = d_in.alu;
        WriteData_in = d_in.wd;
        RegAddr_in   = d_in.ra;
        pc_in        = d_in.pc;
        e_mis = mis_f(mi.op, mi.alu);
        if (mbusy) begin
            e_req = 1'b1;
            e_we = mb_we; e_be = mb_be; e_addr = mb_addr; e_wd = mb_wd;
        end else begin
            e_req  = (is_ld(mi.op) || is_st(mi.op)) && !mdone && !e_mis && !d_req;
            e_we   = is_st(mi.op);
            e_be   = be_f(mi.op, mi.alu[1:0]);
            e_addr = {mi.alu[31:2], 2'b00};
            e_wd   = wd_f(mi.op, mi.wd);
            cnt    = (d_wait < 0) ? $urandom_range(0, 3) : d_wait;
        end
        e_ack = e_req && (cnt == 0);
        if (e_req && !e_ack) cnt--;
        e_stall = e_req && !e_ack;
        m_ack   = e_ack;
        m_rdata = d_rdata;
        #1;
        chk("stall_out", 32'(stall_out), 32'(e_stall));
        chk("m_req", 32'(m_req), 32'(e_req));
        if (e_req) begin
            chk("m_addr", m_addr, e_addr);
            chk("m_byteen", 32'(m_byteen), 32'(e_be));
            chk("m_we", 32'(m_we), 32'(e_we));
            if (e_we) chk("m_wdata", m_wdata, e_wd);
        end
    endtask

    // Advance the model across the clock edge, then check registered outputs.
    task automatic end_cycle();
        bit complete, busy_n;
        complete = e_req && e_ack;
        busy_n   = e_req && !e_ack;
        if (complete && !mdrain && !d_req && is_ld(mi.op))
            mrd = ext_f(mi.op, mi.alu[1:0], d_rdata);
        if (busy_n && !mbusy) begin
            mb_we = e_we; mb_be = e_be; mb_addr = e_addr; mb_wd = e_wd;
        end
        mdrain = busy_n && (mdrain || d_req);
        mbusy  = busy_n;
        if (d_req || e_stall) begin
            mw_rw = 0; mw_mtr = 0; mw_alu = 0; mw_ra = 0;
            mexc = 0; mexc_c = 0;
            mw_pc = d_req ? XPC : mi.pc;
        end else begin
            mw_rw = mi.rw && !e_mis; mw_mtr = mi.mtr;
            mw_alu = mi.alu; mw_ra = mi.ra; mw_pc = mi.pc;
            mexc = e_mis;
            mexc_c = e_mis ? (is_ld(mi.op) ? 5'd4 : 5'd5) : 5'd0;
        end
        if (d_req) begin
            mi = '{1'b0, 1'b0, 4'd0, 32'd0, 32'd0, XPC, 5'd0};
            mdone = 0;
        end else if (!e_stall) begin
            mi = d_in;
            mdone = 0;
        end else begin
            mdone = mdone || complete;
        end
        @(posedge clk);
        @(negedge clk);
        chk("RegWrite_out", 32'(RegWrite_out), 32'(mw_rw));
        chk("MemToReg_out", 32'(MemToReg_out), 32'(mw_mtr));
        chk("ALUOut_out", ALUOut_out, mw_alu);
        chk("RegAddr_out", 32'(RegAddr_out), 32'(mw_ra));
        chk("pc_out", pc_out, mw_pc);
        chk("ReadData_out", ReadData_out, mrd);
        chk("exc_valid_out", 32'(exc_valid_out), 32'(mexc));
        chk("exc_code_out", 32'(exc_code_out), 32'(mexc_c));
    endtask

    task automatic step();
        drive_cycle();
        end_cycle();
    endtask

    ins_t nop;
    int   stalls;

    initial begin
        nop = mk(MOP_NONE, 32'h0, 32'h0);
        d_in = nop; d_req = 0; d_wait = 0; d_rdata = 0;
        rst_n = 0; req = 0; m_ack = 0; m_rdata = 0;
        RegWrite_in = 0; MemToReg_in = 0; MemOp_in = 0;
        ALUOut_in = 0; WriteData_in = 0; RegAddr_in = 0; pc_in = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset pc_out", pc_out, 32'h0000_3000);
        chk("reset ReadData_out", ReadData_out, 32'h0);
        chk("reset m_req", 32'(m_req), 32'h0);
        rst_n = 1;

        // SB to byte 3, zero-wait ack
        d_in = mk(MOP_SB, 32'h0000_1003, 32'h0000_00A5); d_wait = 0;
        step();
        d_in = nop;
        drive_cycle();
        chk("sb byteen", 32'(m_byteen), 32'b1000);
        chk("sb wdata", m_wdata, 32'hA5A5_A5A5);
        chk("sb we", 32'(m_we), 32'h1);
        chk("sb no stall", 32'(stall_out), 32'h0);
        end_cycle();

        // LH upper half, three wait states
        d_in = mk(MOP_LH, 32'h0000_2002, 32'h0);
        step();
        d_in = nop; d_wait = 3; d_rdata = 32'h8001_1234; stalls = 0;
        repeat (4) begin
            drive_cycle();
            if (stall_out) stalls++;
            end_cycle();
        end
        chk("lh stall cycles", 32'(stalls), 32'd3);
        chk("lh data", ReadData_out, 32'hFFFF_8001);

        // LBU / LB from byte 1
        d_wait = 0; d_rdata = 32'h0000_9A00;
        d_in = mk(MOP_LBU, 32'h0000_2001, 32'h0); step();
        d_in = nop; step();
        chk("lbu data", ReadData_out, 32'h0000_009A);
        d_in = mk(MOP_LB, 32'h0000_2001, 32'h0); step();
        d_in = nop; step();
        chk("lb data", ReadData_out, 32'hFFFF_FF9A);

        // flush during WAIT -> drain
        d_in = mk(MOP_LW, 32'h0000_2000, 32'h0); step();
        d_in = nop; d_wait = 3; d_rdata = 32'h1234_5678;
        step();
        d_req = 1; step();
        d_req = 0;
        drive_cycle();
        chk("drain stall", 32'(stall_out), 32'h1);
        end_cycle();
        drive_cycle();
        chk("drain ack stall", 32'(stall_out), 32'h0);
        end_cycle();
        chk("drain pc_out", pc_out, 32'h0000_4180);
        chk("drain RegWrite_out", 32'(RegWrite_out), 32'h0);
        chk("drain data kept", ReadData_out, 32'hFFFF_FF9A);
        d_wait = 0;

`ifdef MEM_ALIGN_CHECK_EN
        d_in = mk(MOP_LW, 32'h0000_2002, 32'h0); step();
        d_in = nop;
        drive_cycle();
        chk("adel m_req", 32'(m_req), 32'h0);
        end_cycle();
        chk("adel valid", 32'(exc_valid_out), 32'h1);
        chk("adel code", 32'(exc_code_out), 32'd4);
        chk("adel regwrite", 32'(RegWrite_out), 32'h0);
        d_in = mk(MOP_SH, 32'h0000_2001, 32'h0); step();
        d_in = nop; step();
        chk("ades valid", 32'(exc_valid_out), 32'h1);
        chk("ades code", 32'(exc_code_out), 32'd5);
`endif

        // random traffic
        d_wait = -1;
        for (int i = 0; i < 3000; i++) begin
            d_in    = rnd_ins();
            d_req   = ($urandom_range(0, 15) == 0);
            d_rdata = $urandom;
            step();
        end
        d_req = 0; d_in = nop;
        step(); step();

        // async reset while a load waits on the bus
        d_in = mk(MOP_LW, 32'h0000_0100, 32'h0); d_wait = 5;
        step();
        d_in = nop;
        step();
        drive_cycle();
        rst_n = 0;
        #1;
        chk("rst m_req", 32'(m_req), 32'h0);
        chk("rst stall_out", 32'(stall_out), 32'h0);
        chk("rst pc_out", pc_out, 32'h0000_3000);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        d_wait = 0;
        step(); step();
        chk("post-rst m_req", 32'(m_req), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
